// File: rtl/sprite_gen.sv
// Bouncing square sprite: per-frame motion with edge bounce, collision freeze, and a
// registered pixel lookup toward the merge stage. Define SPRITE_PATTERN_EN for a round ball bitmap.
module sprite_gen #(
    parameter int          SCR_W      = 640,
    parameter int          SCR_H      = 480,
    parameter int          SP_SIZE    = 16,
    parameter int          SPEED      = 2,
    parameter int          HIT_FRAMES = 30,
    parameter logic [23:0] SP_COLOR   = 24'h173017,
    parameter logic [23:0] HIT_COLOR  = 24'hF02020
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] pixX,
    input  logic [9:0] pixY,
    input  logic [3:0] collision,
    output logic [7:0] R_sp,
    output logic [7:0] G_sp,
    output logic [7:0] B_sp,
    output logic       sp_valid,
    output logic [9:0] posX_sp,
    output logic [9:0] posY_sp,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic signed [10:0] MAX_X = 11'(SCR_W - SP_SIZE);
    localparam logic signed [10:0] MAX_Y = 11'(SCR_H - SP_SIZE);
    localparam logic signed [10:0] STEP  = 11'(SPEED);
    localparam logic [9:0]         X0    = 10'(SCR_W / 2 - SP_SIZE / 2);
    localparam logic [9:0]         Y0    = 10'(SCR_H / 2 - SP_SIZE / 2);
    localparam logic [10:0]        SIZE  = 11'(SP_SIZE);
    localparam logic [7:0]         HIT_N = 8'(HIT_FRAMES);

    state_t     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       dx_q, dx_d, dy_q, dy_d;     // 1 = moving toward larger coordinate
    logic [3:0] coll_q, coll_d;
    logic [7:0] hit_cnt_q, hit_cnt_d;
    logic       dx_c, dy_c;
    logic [10:0] step_x, step_y;

    // Returns {direction, position} after one step with bounce at 0 and lim.
    function automatic logic [10:0] step_axis(input logic [9:0] p, input logic fwd,
                                              input logic signed [10:0] lim);
        logic signed [10:0] n;
        n = fwd ? $signed({1'b0, p}) + STEP : $signed({1'b0, p}) - STEP;
        if (n > lim)
            return {1'b0, lim[9:0]};
        else if (n < 0)
            return {1'b1, 10'd0};
        else
            return {fwd, n[9:0]};
    endfunction

    function automatic logic steer(input logic cur, input logic to_pos, input logic to_neg);
        if (to_pos && !to_neg)
            return 1'b1;
        else if (to_neg && !to_pos)
            return 1'b0;
        else
            return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pos_x_q   <= X0;
            pos_y_q   <= Y0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            coll_q    <= 4'd0;
            hit_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            coll_q    <= coll_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        hit_cnt_d = hit_cnt_q;
        // Collision seen during the frame_start cycle belongs to the next frame.
        coll_d    = frame_start ? collision : (coll_q | collision);

        dx_c   = steer(dx_q, coll_q[0], coll_q[1]);
        dy_c   = steer(dy_q, coll_q[2], coll_q[3]);
        step_x = step_axis(pos_x_q, dx_c, MAX_X);
        step_y = step_axis(pos_y_q, dy_c, MAX_Y);

        if (frame_start) begin
            unique case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (|coll_q) begin
                        // Bounce direction is taken now; position freezes for the hit.
                        state_d   = HIT;
                        dx_d      = dx_c;
                        dy_d      = dy_c;
                        hit_cnt_d = 8'd0;
                    end else begin
                        {dx_d, pos_x_d} = step_x;
                        {dy_d, pos_y_d} = step_y;
                    end
                end
                HIT: begin
                    hit_cnt_d = hit_cnt_q + 8'd1;
                    if (hit_cnt_q + 8'd1 == HIT_N)
                        state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic in_x, in_y, opaque, hit;

`ifdef SPRITE_PATTERN_EN
    localparam logic [15:0] BALL [16] = '{
        16'h07E0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hFFFF,
        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE, 16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h07E0
    };
    logic [3:0] off_x, off_y;
    assign off_x  = pixX[3:0] - pos_x_q[3:0];
    assign off_y  = pixY[3:0] - pos_y_q[3:0];
    assign opaque = BALL[off_y][off_x];
`else
    assign opaque = 1'b1;
`endif

    assign in_x = ({1'b0, pixX} >= {1'b0, pos_x_q}) && ({1'b0, pixX} < {1'b0, pos_x_q} + SIZE);
    assign in_y = ({1'b0, pixY} >= {1'b0, pos_y_q}) && ({1'b0, pixY} < {1'b0, pos_y_q} + SIZE);
    assign hit  = pix_valid && in_x && in_y && opaque && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_valid           <= 1'b0;
            {R_sp, G_sp, B_sp} <= 24'd0;
        end else begin
            sp_valid           <= hit;
            {R_sp, G_sp, B_sp} <= hit ? ((state_q == HIT) ? HIT_COLOR : SP_COLOR) : 24'd0;
        end
    end

    assign posX_sp = pos_x_q;
    assign posY_sp = pos_y_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_sprite_gen.sv
// Self-checking bench for sprite_gen: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a frame-level behavioural model.
module tb_sprite_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] pixX = '0, pixY = '0;
    logic [3:0] collision = '0;
    logic [7:0] R_sp, G_sp, B_sp;
    logic       sp_valid;
    logic [9:0] posX_sp, posY_sp;
    logic [1:0] state_o;

    sprite_gen dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .pixX(pixX), .pixY(pixY), .collision(collision),
        .R_sp(R_sp), .G_sp(G_sp), .B_sp(B_sp), .sp_valid(sp_valid),
        .posX_sp(posX_sp), .posY_sp(posY_sp), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: plain integers, directions as +1/-1.
    int mx, my, mdx, mdy, mst, mcnt, mlatch;
    int mv, mrgb;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int inside_sprite(input int px, input int py);
        int c, r;
        if (px < mx || px >= mx + 16 || py < my || py >= my + 16) return 0;
`ifdef SPRITE_PATTERN_EN
        c = px - mx;
        r = py - my;
        return ((2*c-15)*(2*c-15) + (2*r-15)*(2*r-15) <= 256) ? 1 : 0;
`else
        c = 0;
        r = 0;
        return 1 + c + r;
`endif
    endfunction

    task automatic move(inout int p, inout int d, input int lim);
        int n;
        n = p + 2 * d;
        if (n > lim) begin p = lim; d = -1; end
        else if (n < 0) begin p = 0; d = 1; end
        else p = n;
    endtask

    task automatic model(input logic rst, input logic fs, input logic pv,
                         input int px, input int py, input int col);
        if (!rst) begin
            mv = 0; mrgb = 0; mst = 0; mx = 312; my = 232;
            mdx = 1; mdy = 1; mlatch = 0; mcnt = 0;
            return;
        end
        mv   = (pv && mst != 0) ? inside_sprite(px, py) : 0;
        mrgb = mv ? ((mst == 2) ? 24'hF02020 : 24'h173017) : 0;
        if (fs) begin
            if (mst == 0) mst = 1;
            else if (mst == 1) begin
                if ((mlatch & 1) && !(mlatch & 2)) mdx = 1;
                if ((mlatch & 2) && !(mlatch & 1)) mdx = -1;
                if ((mlatch & 4) && !(mlatch & 8)) mdy = 1;
                if ((mlatch & 8) && !(mlatch & 4)) mdy = -1;
                if (mlatch != 0) begin mst = 2; mcnt = 0; end
                else begin move(mx, mdx, 624); move(my, mdy, 464); end
            end else begin
                mcnt++;
                if (mcnt == 30) mst = 1;
            end
            mlatch = col;
        end else begin
            mlatch = mlatch | col;
        end
    endtask

    // One clock: drive, advance model, sample on the falling edge, compare against model.
    task automatic cyc(input logic rst, input logic fs, input logic pv,
                       input int px, input int py, input logic [3:0] col);
        reset = rst; frame_start = fs; pix_valid = pv;
        pixX = 10'(px); pixY = 10'(py); collision = col;
        model(rst, fs, pv, px, py, int'(col));
        @(posedge clk);
        @(negedge clk);
        check("posX", int'(posX_sp), mx);
        check("posY", int'(posY_sp), my);
        check("state", int'(state_o), mst);
        check("sp_valid", int'(sp_valid), mv);
        check("rgb", int'({R_sp, G_sp, B_sp}), mrgb);
    endtask

    task automatic frame();
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 4'd0);
    endtask

    typedef struct {
        logic        rst, fs, pv;
        int          px, py;
        logic [3:0]  col;
        int          st, x, y;
        logic        v;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        tbl[0]  = '{1'b0, 1'b0, 1'b0,   0,   0, 4'd0, 0, 312, 232, 1'b0, 24'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 312, 232, 4'd0, 0, 312, 232, 1'b0, 24'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0,   0,   0, 4'd0, 0, 312, 232, 1'b0, 24'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 312, 232, 4'd0, 0, 312, 232, 1'b0, 24'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0,   0,   0, 4'd0, 1, 312, 232, 1'b0, 24'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0,   0,   0, 4'd0, 1, 312, 232, 1'b0, 24'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0,   0,   0, 4'd0, 1, 314, 234, 1'b0, 24'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 314, 234, 4'd0, 1, 314, 234, 1'b1, 24'h173017};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 330, 234, 4'd0, 1, 314, 234, 1'b0, 24'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 329, 249, 4'd0, 1, 314, 234, 1'b1, 24'h173017};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 313, 240, 4'd0, 1, 314, 234, 1'b0, 24'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 320, 250, 4'd0, 1, 314, 234, 1'b0, 24'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 320, 240, 4'd0, 1, 314, 234, 1'b0, 24'h0};

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].fs, tbl[i].pv, tbl[i].px, tbl[i].py, tbl[i].col);
            check($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
            check($sformatf("tbl%0d_x", i), int'(posX_sp), tbl[i].x);
            check($sformatf("tbl%0d_y", i), int'(posY_sp), tbl[i].y);
            check($sformatf("tbl%0d_valid", i), int'(sp_valid), int'(tbl[i].v));
            check($sformatf("tbl%0d_rgb", i), int'({R_sp, G_sp, B_sp}), int'(tbl[i].rgb));
        end

        // Right-side hit mid-frame: freeze, red, then resume heading left after 30 frames.
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 4'b0010);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 4'b0000);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 4'b0000);
        check("hit_state", int'(state_o), 2);
        check("hit_frozen_x", int'(posX_sp), 314);
        cyc(1'b1, 1'b0, 1'b1, 320, 240, 4'd0);
        check("hit_rgb", int'({R_sp, G_sp, B_sp}), 24'hF02020);
        for (int f = 0; f < 29; f++) frame();
        check("hit_29_state", int'(state_o), 2);
        check("hit_29_x", int'(posX_sp), 314);
        frame();
        check("resume_state", int'(state_o), 1);
        frame();
        check("resume_left_x", int'(posX_sp), 312);

        // Bounce off the right edge: clamp to 624, then come back to 622.
        n = 0;
        while (!(mx == 624 && mdx == -1) && n < 800) begin frame(); n++; end
        check("edge_reached", (n < 800) ? 1 : 0, 1);
        check("edge_clamp_x", int'(posX_sp), 624);
        frame();
        check("edge_back_x", int'(posX_sp), 622);

        // Collision during frame_start counts for the following frame.
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 4'b0001);
        check("late_coll_state", int'(state_o), 1);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 4'b0000);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 4'b0000);
        check("late_coll_hit", int'(state_o), 2);
        frame();
        // Reset wins over frame_start while frozen; latch must come back clear.
        cyc(1'b0, 1'b1, 1'b1, 320, 240, 4'b1000);
        check("rst_hit_state", int'(state_o), 0);
        check("rst_hit_x", int'(posX_sp), 312);
        check("rst_hit_y", int'(posY_sp), 232);
        check("rst_hit_rgb", int'({R_sp, G_sp, B_sp}), 0);
        frame();
        frame();
        check("rst_latch_clear_state", int'(state_o), 1);
        check("rst_latch_clear_x", int'(posX_sp), 314);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       r, fs, pv;
            logic [3:0] c;
            int         px, py;
            r  = ($urandom_range(0, 599) != 0);
            fs = ($urandom_range(0, 3) == 0);
            pv = $urandom_range(0, 1) == 1;
            px = mx - 4 + $urandom_range(0, 24);
            py = my - 4 + $urandom_range(0, 24);
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            c  = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            cyc(r, fs, pv, px, py, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_gen.md
SPRITE_GEN -- requirements
Module: sprite_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): SCR_W, 640, visible width; SCR_H, 480, visible height; SP_SIZE, 16, square sprite side; SPEED, 2, pixels moved per frame; HIT_FRAMES, 30, freeze length after a hit; SP_COLOR, 24'h173017, normal RGB; HIT_COLOR, 24'hF02020, RGB while frozen.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each frame
- pix_valid  in  1  pixX/pixY carry a requested raster pixel
- pixX, pixY  in  10  raster coordinate of requested pixel
- collision  in  4  from merge: [0] left, [1] right, [2] top, [3] bottom side of sprite hit
- R_sp, G_sp, B_sp  out  8  sprite pixel colour toward merge
- sp_valid  out  1  R/G/B_sp belong to an opaque sprite pixel
- posX_sp, posY_sp  out  10  sprite top-left corner toward merge
- state_o  out  2  current FSM state (IDLE=0, RUN=1, HIT=2)

Function
REQ-003 SHALL implement FSM IDLE -> RUN on first frame_start; RUN -> HIT on frame_start when latched collision is nonzero; HIT -> RUN on the frame_start where hit counter reaches HIT_FRAMES.
REQ-004 SHALL OR collision into a sticky 4-bit latch every cycle; latch cleared on each frame_start after being sampled; collision arriving in the frame_start cycle goes to the next frame.
REQ-005 SHALL, in RUN at frame_start, first apply latched collision: bit0 -> dx=+1, bit1 -> dx=-1, bit2 -> dy=+1, bit3 -> dy=-1; bits 0 and 1 both set -> dx unchanged; likewise bits 2 and 3 for dy.
REQ-006 SHALL then step position by SPEED in dx/dy direction with edge clamp: next X > SCR_W-SP_SIZE -> X=SCR_W-SP_SIZE, dx=-1; next X < 0 -> X=0, dx=+1; Y identical with SCR_H; arithmetic in 11-bit signed, no wrap-around.
REQ-007 SHALL hold position and direction in IDLE and HIT; in HIT an 8-bit counter increments per frame_start, zeroed on entry to HIT.
REQ-008 SHALL register pixel output with 1-cycle latency: sp_valid=1 when pix_valid and posX_sp<=pixX<posX_sp+SP_SIZE and posY_sp<=pixY<posY_sp+SP_SIZE, and state not IDLE.
REQ-009 SHALL output SP_COLOR in RUN, HIT_COLOR in HIT when sp_valid=1; R/G/B_sp=0 when sp_valid=0.
REQ-010 SHALL evaluate a pix_valid in the same cycle as frame_start against pre-update position.
REQ-011 SHALL drive posX_sp/posY_sp directly from position registers (visible one cycle after frame_start).

Reset
REQ-012 SHALL, when reset=0 at a clock edge, set state IDLE, posX_sp=SCR_W/2-SP_SIZE/2 (312), posY_sp=SCR_H/2-SP_SIZE/2 (232), dx=dy=+1, collision latch 0, hit counter 0, sp_valid 0, R/G/B_sp 0.
REQ-013 SHALL give reset priority over frame_start and pix_valid in the same cycle; reset mid-HIT returns to IDLE with no residual colour.

Configuration
REQ-014 SHALL compile an internal 16x16 1-bit bitmap ROM when SPRITE_PATTERN_EN is defined: sp_valid additionally requires ROM bit [pixY-posY_sp][pixX-posX_sp]=1 (ball shape, corners transparent); without it the whole square is opaque.

Verification
REQ-015 Reset low 3 cycles, release -> posX_sp=312, posY_sp=232, state_o=0, sp_valid=0.
REQ-016 Two frame_start pulses, collision=0 -> after second: posX_sp=314, posY_sp=234, state_o=1.
REQ-017 RUN, pix_valid with pixX=314,pixY=234 -> next cycle sp_valid=1, RGB=17/30/17; pixX=330 -> sp_valid=0, RGB=0.
REQ-018 Force posX_sp=623 heading right, frame_start -> posX_sp=624, dx=-1; next frame -> 622.
REQ-019 collision=4'b0010 pulsed mid-frame, frame_start -> state_o=2, position frozen, in-sprite pixel RGB=F0/20/20; after 30 further frame_start -> state_o=1, moving left.
REQ-020 Reset asserted in HIT together with frame_start -> state_o=0, position 312/232, collision latch 0.
